// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side handshake bundle for icache_sa.
// master = fetch/memory environment, slave = the cache.
interface icache_sa_if #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BLOCK_WORDS = 32
);
    logic                          req_valid;
    logic [ADDR_W-1:0]             req_addr;
    logic                          req_ready;
    logic                          resp_valid;
    logic [WORD_W-1:0]             resp_data;
    logic                          flush;
    logic                          mem_req;
    logic [ADDR_W-1:0]             mem_addr;
    logic                          mem_ready;
    logic [WORD_W*BLOCK_WORDS-1:0] mem_block;

    modport master (
        output req_valid, req_addr, flush, mem_ready, mem_block,
        input  req_ready, resp_valid, resp_data, mem_req, mem_addr
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_ready, mem_block,
        output req_ready, resp_valid, resp_data, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache: one-cycle lookup, block refill on miss,
// round-robin replacement per set, deferred flush and saturating counters.
module icache_sa #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BLOCK_WORDS = 32,
    parameter int SETS        = 16,
    parameter int WAYS        = 2
) (
    input  logic        clk,
    input  logic        rst,
    icache_sa_if.slave  bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS} state_t;

    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]             addr_q;
    logic [SETS-1:0][WAYS-1:0]     valid_q;
    logic [SETS-1:0][PTR_W-1:0]    ptr_q;
    logic [TAG_W-1:0]              tag_q  [SETS][WAYS];
    block_t                        data_q [SETS][WAYS];
    logic                          flush_pend;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [PTR_W-1:0] hit_way;
    logic [PTR_W-1:0] victim;
    logic             victim_free;
    logic             req_ready;
    logic             accept;
    logic             do_flush;
    logic             fill_en;
    block_t           fill_words;

    assign off = addr_q[OFF_W-1:0];
    assign idx = addr_q[OFF_W +: IDX_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    assign fill_words = bus.mem_block;

    // Tag compare across all ways of the latched set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim      = ptr_q[idx];
        victim_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_free && !valid_q[idx][w]) begin
                victim_free = 1'b1;
                victim      = PTR_W'(w);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state, request acceptance and flush execution.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        do_flush  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.flush || flush_pend) begin
                    do_flush = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    if (bus.req_valid) state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = hit ? S_IDLE : S_MISS;
            S_MISS:   if (bus.mem_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (rst) begin
            state_d   = S_IDLE;
            req_ready = 1'b0;
            do_flush  = 1'b0;
        end
    end

    assign bus.req_ready = req_ready;
    assign accept        = req_ready && bus.req_valid;
    assign fill_en       = (state_q == S_MISS) && bus.mem_ready && !rst;

    // Control, valid bits, pointers, responses and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q         <= '0;
            valid_q        <= '0;
            ptr_q          <= '0;
            flush_pend     <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            if (accept) addr_q <= bus.req_addr;

            if (do_flush) begin
                valid_q    <= '0;
                flush_pend <= 1'b0;
            end else if (bus.flush && state_q != S_IDLE) begin
                flush_pend <= 1'b1;
            end

            if (state_q == S_LOOKUP) begin
                if (hit) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_data  <= data_q[idx][hit_way][off];
                    if (hit_count != '1) hit_count <= hit_count + 32'd1;
                end else begin
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= {tag, idx, {OFF_W{1'b0}}};
                    if (miss_count != '1) miss_count <= miss_count + 32'd1;
                end
            end

            if (fill_en) begin
                valid_q[idx][victim] <= 1'b1;
                if (!victim_free)
                    ptr_q[idx] <= (WAYS == 1) ? '0 : ptr_q[idx] + PTR_W'(1);
                bus.resp_valid <= 1'b1;
                bus.resp_data  <= fill_words[off];
                bus.mem_req    <= 1'b0;
            end
        end
    end

    // Tag and data arrays; written only on a refill.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx][victim]  <= tag;
            data_q[idx][victim] <= fill_words;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed scenarios followed by random
// fetches, checked against a set/way model of the cache contents.
module tb_icache_sa;
    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int BLOCK_WORDS = 32;
    localparam int SETS        = 16;
    localparam int WAYS        = 2;
    localparam int OFF_W       = $clog2(BLOCK_WORDS);
    localparam int IDX_W       = $clog2(SETS);
    localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count, miss_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit                 mvalid [SETS][WAYS];
    int                 mtag   [SETS][WAYS];
    logic [BLOCK_W-1:0] mdata  [SETS][WAYS];
    int                 mptr   [SETS];
    int                 mhits, mmiss;
    bit                 dead_blk;

    int                 n, r, lat;
    logic [31:0]        a;
    logic [BLOCK_W-1:0] junk;

    icache_sa_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .BLOCK_WORDS(BLOCK_WORDS)) bus ();

    icache_sa #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .BLOCK_WORDS(BLOCK_WORDS),
        .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++) mptr[s] = 0;
        mhits = 0;
        mmiss = 0;
    endtask

    // Waits (bounded) for req_ready with req_valid held, then steps into LOOKUP.
    task automatic issue(input logic [31:0] addr);
        int k;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        #1;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("resp_pulse_low", bus.resp_valid, 0);
    endtask

    // One full fetch: predicts hit/miss from the model, services any miss
    // after `lt` wait cycles, optionally pulsing flush while the miss waits.
    task automatic do_fetch(input logic [31:0] addr, input int lt, input bit fl_miss);
        int s, t, o, way;
        bit h;
        logic [BLOCK_W-1:0] blk;
        o = int'(addr % BLOCK_WORDS);
        s = int'((addr / BLOCK_WORDS) % SETS);
        t = int'(addr / (BLOCK_WORDS * SETS));
        h = 1'b0;
        way = 0;
        for (int w = 0; w < WAYS; w++)
            if (mvalid[s][w] && mtag[s][w] == t) begin h = 1'b1; way = w; end

        issue(addr);
        @(posedge clk); #1;
        if (h) begin
            mhits++;
            chk("hit_resp_valid", bus.resp_valid, 1);
            chk("hit_resp_data", bus.resp_data, mdata[s][way][o*WORD_W +: WORD_W]);
            chk("hit_no_mem_req", bus.mem_req, 0);
        end else begin
            mmiss++;
            chk("miss_resp_valid", bus.resp_valid, 0);
            chk("miss_mem_req", bus.mem_req, 1);
            chk("miss_mem_addr", bus.mem_addr, {addr[31:OFF_W], {OFF_W{1'b0}}});
            for (int i = 0; i < lt; i++) begin
                if (fl_miss && i == 0) bus.flush = 1'b1;
                @(posedge clk); #1;
                bus.flush = 1'b0;
                chk("mem_req_held", bus.mem_req, 1);
            end
            for (int i = 0; i < BLOCK_WORDS; i++)
                blk[i*WORD_W +: WORD_W] = dead_blk ? 32'hDEAD0000 + i : $urandom;
            bus.mem_block = blk;
            bus.mem_ready = 1'b1;
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            chk("fill_resp_valid", bus.resp_valid, 1);
            chk("fill_resp_data", bus.resp_data, blk[o*WORD_W +: WORD_W]);
            chk("fill_mem_req_low", bus.mem_req, 0);
            way = -1;
            for (int w = 0; w < WAYS; w++)
                if (way < 0 && !mvalid[s][w]) way = w;
            if (way < 0) begin
                way = mptr[s];
                mptr[s] = (mptr[s] + 1) % WAYS;
            end
            mvalid[s][way] = 1'b1;
            mtag[s][way]   = t;
            mdata[s][way]  = blk;
            if (fl_miss && lt > 0) begin
                chk("pending_flush_ready", bus.req_ready, 0);
                model_flush();
            end
        end
        chk("hit_count", hit_count, mhits);
        chk("miss_count", miss_count, mmiss);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_block = '0;
        dead_blk      = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", bus.req_ready, 1);

        // Cold miss then hit in the same block
        dead_blk = 1'b1;
        do_fetch(32'd129, 1, 1'b0);
        chk("cold_word1", bus.resp_data, 32'hDEAD0001);
        chk("cold_mem_addr", bus.mem_addr, 32'd128);
        dead_blk = 1'b0;
        do_fetch(32'd130, 0, 1'b0);
        chk("hit_word2", bus.resp_data, 32'hDEAD0002);

        // Conflict set 4: third tag evicts way 0, then 641 hits and 129 misses
        do_fetch(32'd641, 2, 1'b0);
        do_fetch(32'd1153, 0, 1'b0);
        do_fetch(32'd641, 0, 1'b0);
        do_fetch(32'd129, 1, 1'b0);

        // Flush in IDLE blocks a simultaneous request
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'd130;
        #1;
        chk("flush_idle_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("flush_not_accepted", bus.req_ready, 1);
        model_flush();
        do_fetch(32'd130, 1, 1'b0);

        // Flush while waiting on memory
        do_fetch(32'd641, 2, 1'b1);
        do_fetch(32'd641, 1, 1'b0);

        // Reset mid-miss; a late mem_ready must be ignored
        issue(32'd1153);
        @(posedge clk); #1;
        chk("rmm_mem_req", bus.mem_req, 1);
        rst = 1'b1;
        #1;
        chk("rmm_ready_in_rst", bus.req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rmm_mem_req_low", bus.mem_req, 0);
        chk("rmm_hits", hit_count, 0);
        chk("rmm_misses", miss_count, 0);
        for (int i = 0; i < BLOCK_WORDS; i++) junk[i*WORD_W +: WORD_W] = $urandom;
        bus.mem_block = junk;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        chk("late_ready_no_resp", bus.resp_valid, 0);
        model_reset();
        do_fetch(32'd129, 1, 1'b0);
        do_fetch(32'd1153, 0, 1'b0);

        // Random fetches over a few conflicting sets
        for (int it = 0; it < 120; it++) begin
            a = ($urandom_range(0, 3) << (OFF_W + IDX_W)) |
                ($urandom_range(3, 5) << OFF_W) |
                $urandom_range(0, BLOCK_WORDS - 1);
            r = $urandom_range(0, 9);
            lat = (r == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            if (r == 0) begin
                bus.flush = 1'b1;
                #1;
                chk("rand_flush_ready", bus.req_ready, 0);
                @(posedge clk); #1;
                bus.flush = 1'b0;
                model_flush();
            end
            do_fetch(a, lat, r == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
